// File: rtl/vmem_pkg.sv
// Shared constants, clear-sequencer state type and pixel address helper for the
// frame-buffer controller.
package vmem_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Linear row-major address; callers truncate to their own address width.
    function automatic logic [31:0] pix_addr(input logic [9:0] h,
                                             input logic [9:0] v,
                                             input int         h_res = H_RES);
        logic [31:0] lin;
        lin = 32'(v) * 32'(h_res) + 32'(h);
        return lin;
    endfunction

endpackage

// File: rtl/vmem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the preferred requester and
// flips to the other one after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !ptr)) gnt = 2'b01;
            else if (req[1])                 gnt = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)     ptr <= 1'b0;
        else if (gnt[0]) ptr <= 1'b1;
        else if (gnt[1]) ptr <= 1'b0;
    end

endmodule

// File: rtl/vmem_ctrl.sv
// Frame-buffer RAM controller: scan-out reads own the active region; the clear
// sequencer and two round-robin pixel writers share the blanking cycles.
module vmem_ctrl #(
    parameter int H_RES  = vmem_pkg::H_RES,
    parameter int V_RES  = vmem_pkg::V_RES,
    parameter int ADDR_W = vmem_pkg::ADDR_W,
    parameter int DATA_W = vmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    input  logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import vmem_pkg::*;

    localparam logic [31:0] FB_SIZE = 32'(H_RES * V_RES);

    // Handshake: a requester transfers on the cycle where valid && ready; ready is
    // combinational, only raised while valid is high, and addr/data stay put until then.
    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] color, color_nxt;
    logic              read_slot, write_slot, clr_slot, arb_en;
    logic              req0_ok, req1_ok, rd_q;
    logic [1:0]        gnt;

    // Slot outputs are forced quiet while reset is held.
    assign read_slot  = resetn && vga_valid;
    assign write_slot = resetn && !vga_valid;
    assign clr_slot   = write_slot && (state == CLEAR);
    assign arb_en     = write_slot && (state != CLEAR);
    assign req0_ok    = 32'(req0_addr) < FB_SIZE;
    assign req1_ok    = 32'(req1_addr) < FB_SIZE;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({req1_valid, req0_valid}),
        .en     (arb_en),
        .gnt    (gnt)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        color_nxt = color;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                    color_nxt = clr_color;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_slot) begin
                    if (32'(ptr) == FB_SIZE - 32'd1) state_nxt = DONE;
                    else                             ptr_nxt   = ptr + ADDR_W'(1);
                end
            end
            DONE: begin
                clr_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (read_slot) begin
            mem_en   = 1'b1;
            mem_addr = ADDR_W'(pix_addr(h_addr, v_addr, H_RES));
        end else if (clr_slot) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ptr;
            mem_wdata = color;
        end else if (gnt[0] && req0_ok) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req0_addr;
            mem_wdata = req0_data;
        end else if (gnt[1] && req1_ok) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req1_addr;
            mem_wdata = req1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            color    <= '0;
            rd_q     <= 1'b0;
            vga_data <= '0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            color    <= color_nxt;
            rd_q     <= read_slot;
            // Blanking reads return black so scan-out never shows stale RAM data.
            vga_data <= rd_q ? mem_rdata : '0;
            wr_drop  <= (gnt[0] && !req0_ok) || (gnt[1] && !req1_ok);
        end
    end

endmodule

// File: tb/tb_vmem_ctrl.sv
// Self-checking bench for vmem_ctrl on a reduced 8x4 frame buffer with a behavioural
// RAM and a reference model of slots, round-robin grants and the clear sequence.
module tb_vmem_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int FB = H * V;
    localparam int AW = 19;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          resetn;
    logic [9:0]    h_addr, v_addr;
    logic          vga_valid;
    logic [DW-1:0] vga_data;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          clr_start, clr_busy, clr_done, wr_drop;
    logic [DW-1:0] clr_color;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic          load_en = 1'b0;
    logic [4:0]    load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [DW-1:0] ram [0:FB-1];
    logic [DW-1:0] ref_ram [0:FB-1];
    logic [DW-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vmem_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_drop    (wr_drop),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (load_en) ram[load_addr] <= load_data;
        else if (mem_en && mem_addr < AW'(FB)) begin
            if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[4:0]];
        end
    end

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return AW'(307200);
            1:       return AW'(FB + int'($urandom_range(0, 9)));
            default: return AW'($urandom_range(0, FB - 1));
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b0; vga_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < FB; i++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = 5'(i);
            load_data = (i == 19) ? 24'hABCDEF : DW'($urandom);
            ref_ram[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; vga_valid = 1'b0; req0_valid = 1'b1; req0_addr = AW'(3); req0_data = 24'h111111;
        req1_valid = 1'b0; clr_start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_tests++;
        if ({req0_ready, req1_ready, mem_en, mem_we, clr_busy, clr_done, wr_drop} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {req0_ready, req1_ready, mem_en, mem_we, clr_busy, clr_done, wr_drop});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, vga_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %0d wdata %h vga %h expected all 0", mem_addr, mem_wdata, vga_data);
        end
        @(negedge clk);
        resetn = 1'b1; req0_valid = 1'b0;
    endtask

    task automatic test_scanout();
        logic [AW-1:0] ea;
        logic [DW-1:0] ev;
        logic          vv;
        exp_q = {};
        exp_q.push_back('0);
        exp_q.push_back('0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            vv = (c == 0) || ($urandom_range(0, 3) != 0);
            vga_valid = vv;
            h_addr = (c == 0) ? 10'd3 : 10'($urandom_range(0, H - 1));
            v_addr = (c == 0) ? 10'd2 : 10'($urandom_range(0, V - 1));
            #2;
            ea = vv ? AW'(int'(v_addr) * H + int'(h_addr)) : '0;
            n_tests++;
            if ({mem_en, mem_we, mem_addr} !== {vv, 1'b0, ea}) begin
                n_fail++;
                $display("FAIL scan_addr: got en %b we %b addr %0d expected en %b we 0 addr %0d", mem_en, mem_we, mem_addr, vv, ea);
            end
            ev = exp_q.pop_front();
            n_tests++;
            if (vga_data !== ev) begin
                n_fail++;
                $display("FAIL scan_data: cycle %0d got %h expected %h", c, vga_data, ev);
            end
            exp_q.push_back(vv ? ref_ram[ea[4:0]] : '0);
        end
        @(negedge clk);
        vga_valid = 1'b0;
    endtask

    task automatic test_blocking();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = AW'(10); req0_data = 24'h123456;
        for (int c = 0; c < 5; c++) begin
            vga_valid = 1'b1; h_addr = 10'(c); v_addr = 10'd1;
            #2;
            n_tests++;
            if ({req0_ready, mem_we} !== 2'b00) begin
                n_fail++;
                $display("FAIL block_active: got ready %b we %b expected 0 0", req0_ready, mem_we);
            end
            @(negedge clk);
        end
        vga_valid = 1'b0;
        #2;
        n_tests++;
        if ({req0_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, AW'(10), 24'h123456}) begin
            n_fail++;
            $display("FAIL block_release: got ready %b en %b we %b addr %0d data %h expected 1 1 1 10 123456",
                     req0_ready, mem_en, mem_we, mem_addr, mem_wdata);
        end
        ref_ram[10] = 24'h123456;
        @(negedge clk);
        req0_valid = 1'b0;
    endtask

    task automatic test_contention();
        logic          pend0, pend1, drop_prev, vv, e_en, e_we;
        logic [AW-1:0] a0, a1, e_addr;
        logic [DW-1:0] d0, d1, e_wd;
        int            pref, g;
        do_reset();
        pend0 = 1'b0; pend1 = 1'b0; pref = 0; drop_prev = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (!pend0 && (c < 4 || $urandom_range(0, 1) == 1)) begin pend0 = 1'b1; a0 = rand_addr(); d0 = DW'($urandom); end
            if (!pend1 && (c < 4 || $urandom_range(0, 1) == 1)) begin pend1 = 1'b1; a1 = rand_addr(); d1 = DW'($urandom); end
            vv = (c >= 4) && ($urandom_range(0, 3) == 0);
            vga_valid = vv;
            h_addr = 10'($urandom_range(0, H - 1));
            v_addr = 10'($urandom_range(0, V - 1));
            req0_valid = pend0; req0_addr = a0; req0_data = d0;
            req1_valid = pend1; req1_addr = a1; req1_data = d1;
            #2;
            n_tests++;
            if (wr_drop !== drop_prev) begin
                n_fail++;
                $display("FAIL rr_drop: cycle %0d got %b expected %b", c, wr_drop, drop_prev);
            end
            g = -1;
            if (!vv) begin
                if (pend0 && pend1) g = pref;
                else if (pend0)     g = 0;
                else if (pend1)     g = 1;
            end
            n_tests++;
            if ({req1_ready, req0_ready} !== {g == 1, g == 0}) begin
                n_fail++;
                $display("FAIL rr_grant: cycle %0d got %b%b expected grant %0d", c, req1_ready, req0_ready, g);
            end
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (vv) begin
                e_en = 1'b1; e_addr = AW'(int'(v_addr) * H + int'(h_addr));
            end else if (g == 0 && a0 < AW'(FB)) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = a0; e_wd = d0;
            end else if (g == 1 && a1 < AW'(FB)) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = a1; e_wd = d1;
            end
            n_tests++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wd}) begin
                n_fail++;
                $display("FAIL rr_port: cycle %0d got %b %b %0d %h expected %b %b %0d %h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wd);
            end
            drop_prev = 1'b0;
            if (g == 0) begin
                pref = 1; pend0 = 1'b0;
                if (a0 < AW'(FB)) ref_ram[a0[4:0]] = d0; else drop_prev = 1'b1;
            end else if (g == 1) begin
                pref = 0; pend1 = 1'b0;
                if (a1 < AW'(FB)) ref_ram[a1[4:0]] = d1; else drop_prev = 1'b1;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; vga_valid = 1'b0;
        #2;
        n_tests++;
        if (wr_drop !== drop_prev) begin
            n_fail++;
            $display("FAIL rr_drop_last: got %b expected %b", wr_drop, drop_prev);
        end
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] addrs [3];
        logic          ok;
        addrs[0] = AW'(FB - 1); addrs[1] = AW'(FB); addrs[2] = AW'(307200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vga_valid = 1'b0; req0_valid = 1'b0;
            req1_valid = 1'b1; req1_addr = addrs[i]; req1_data = DW'($urandom);
            #2;
            ok = addrs[i] < AW'(FB);
            n_tests++;
            if ({req1_ready, mem_en, mem_we} !== {1'b1, ok, ok}) begin
                n_fail++;
                $display("FAIL oor_grant: addr %0d got ready %b en %b we %b expected 1 %b %b",
                         addrs[i], req1_ready, mem_en, mem_we, ok, ok);
            end
            if (ok) ref_ram[addrs[i][4:0]] = req1_data;
            @(negedge clk);
            req1_valid = 1'b0;
            #2;
            n_tests++;
            if (wr_drop !== !ok) begin
                n_fail++;
                $display("FAIL oor_drop: addr %0d got %b expected %b", addrs[i], wr_drop, !ok);
            end
            @(negedge clk);
            #2;
            n_tests++;
            if (wr_drop !== 1'b0) begin
                n_fail++;
                $display("FAIL oor_drop_pulse: addr %0d got %b expected 0", addrs[i], wr_drop);
            end
        end
    endtask

    task automatic test_clear(input bit toggle);
        logic [DW-1:0] col;
        logic          vv;
        int            ptr_m, budget;
        col = toggle ? DW'($urandom) : 24'h00FF00;
        @(negedge clk);
        vga_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b1; clr_color = col;
        req0_valid = 1'b1; req0_addr = AW'($urandom_range(0, FB - 1)); req0_data = DW'($urandom);
        #2;
        n_tests++;
        if ({req0_ready, mem_we, mem_addr, mem_wdata, clr_busy} !== {2'b11, req0_addr, req0_data, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_req_wins: got ready %b we %b addr %0d busy %b expected 1 1 %0d 0",
                     req0_ready, mem_we, mem_addr, clr_busy, req0_addr);
        end
        ref_ram[req0_addr[4:0]] = req0_data;
        ptr_m = 0;
        budget = 0;
        while (ptr_m < FB && budget < 400) begin
            @(negedge clk);
            if (budget == 0) begin req0_addr = AW'($urandom_range(0, FB - 1)); req0_data = DW'($urandom); end
            clr_start = (budget == 7);
            clr_color = ~col;
            vv = toggle && ($urandom_range(0, 1) == 1);
            vga_valid = vv;
            h_addr = 10'($urandom_range(0, H - 1));
            v_addr = 10'($urandom_range(0, V - 1));
            #2;
            n_tests++;
            if ({clr_busy, clr_done, req0_ready} !== 3'b100) begin
                n_fail++;
                $display("FAIL clr_status: got busy %b done %b ready %b expected 1 0 0", clr_busy, clr_done, req0_ready);
            end
            n_tests++;
            if (vv) begin
                if ({mem_en, mem_we} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL clr_read_slot: got en %b we %b expected 1 0", mem_en, mem_we);
                end
            end else begin
                if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, AW'(ptr_m), col}) begin
                    n_fail++;
                    $display("FAIL clr_write: got en %b we %b addr %0d data %h expected 1 1 %0d %h",
                             mem_en, mem_we, mem_addr, mem_wdata, ptr_m, col);
                end
                ref_ram[ptr_m] = col;
                ptr_m++;
            end
            budget++;
        end
        if (ptr_m < FB) begin
            n_tests++;
            n_fail++;
            $display("FAIL clr_timeout: got %0d writes expected %0d", ptr_m, FB);
        end
        @(negedge clk);
        clr_start = 1'b0; vga_valid = 1'b0;
        #2;
        n_tests++;
        if ({clr_done, clr_busy, req0_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL clr_done: got done %b busy %b ready %b expected 1 0 1", clr_done, clr_busy, req0_ready);
        end
        ref_ram[req0_addr[4:0]] = req0_data;
        @(negedge clk);
        req0_valid = 1'b0;
        #2;
        n_tests++;
        if ({clr_done, clr_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_done_pulse: got done %b busy %b expected 0 0", clr_done, clr_busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        vga_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b1; clr_color = 24'h0000FF;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        n_tests++;
        if ({clr_busy, mem_we, mem_addr} !== {2'b11, AW'(4)}) begin
            n_fail++;
            $display("FAIL midclr_progress: got busy %b we %b addr %0d expected 1 1 4", clr_busy, mem_we, mem_addr);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #2;
        n_tests++;
        if ({clr_busy, clr_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL midclr_reset: got busy %b done %b expected 0 0", clr_busy, clr_done);
        end
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #2;
            n_tests++;
            if ({clr_busy, clr_done, mem_en} !== 3'b000) begin
                n_fail++;
                $display("FAIL midclr_quiet: cycle %0d got busy %b done %b en %b expected 0 0 0", c, clr_busy, clr_done, mem_en);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; vga_valid = 1'b0; h_addr = '0; v_addr = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        clr_start = 1'b0; clr_color = '0;
        test_reset();
        preload();
        test_scanout();
        test_blocking();
        test_contention();
        test_out_of_range();
        test_clear(1'b0);
        test_clear(1'b1);
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
